alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. execute stage (requester 0) and a branch/address unit (requester 1).
- Accepts operations via a valid/ready handshake and arbitrates round-robin.
- Drives the ALU from registered operands, captures result/zero one cycle later, and returns them on a shared response channel tagged with requester id.
- Sits between the pipeline control and the ALU instance at CPU top level.

Parameters:
- WIDTH, 32, operand/result width.
- OP_W, 4, ALU op-code width (ALUC).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept.
- req0_a, req0_b  in  WIDTH each  requester 0 operands (signed).
- req0_op  in  OP_W  requester 0 op.
- req1_a, req1_b, req1_op  in  as above  requester 1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  compare flag.
- rsp_err  out  1  illegal op.
- alu_a, alu_b  out  WIDTH  to ALU A/B.
- alu_op  out  OP_W  to ALU ALUC.
- alu_result  in  WIDTH  from ALU result.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - rst is synchronous and active-high; it wins over every other event.
  - Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0, last_grant=1 (requester 0 wins the first tie).
- Legal ops:
  - 0 add, 1 sub, 2 and, 3 or, 4 slt (signed): return alu_result, rsp_zero=0.
  - 5 ne, 6 eq: return rsp_zero=alu_zero, rsp_result=0.
  - 7..15 illegal.
- IDLE:
  - If no req_valid: stay.
  - Winner = the only valid requester, or on a tie the one != last_grant.
  - req_ready[winner]=1 combinationally in IDLE only; the loser's ready=0.
  - On handshake: latch operands and op into alu_a/alu_b/alu_op, set rsp_id=winner, last_grant=winner.
  - Legal op: go to EXEC.
  - Illegal op: go to RESP with rsp_err=1, rsp_result=0, rsp_zero=0. The ALU registers still load.
- EXEC (1 cycle):
  - ALU inputs are stable from registers.
  - At the clock edge, capture rsp_result/rsp_zero per the op rules, rsp_err=0, then go to RESP.
- RESP:
  - rsp_valid=1; all response fields held stable.
  - On rsp_ready: rsp_valid falls next cycle, go to IDLE.
  - req_ready=0 throughout.
- Timing:
  - Latency: accept edge -> rsp_valid high 2 cycles later (legal op) or 1 cycle later (illegal op).
  - Max throughput: one op per 3 cycles.
- Output stability: alu_a/alu_b/alu_op change only on accept, so the ALU never sees glitching inputs.
- Requester behaviour:
  - A requester dropping valid before ready is permitted; nothing is latched.
  - A held, ungranted request waits at most one operation (round-robin fairness).
- Reset mid-operation: the in-flight op is discarded with no response; state returns to IDLE next cycle.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_grant0, perf_grant1 (16 bit each), counting accepted ops per requester, saturating at 16'hFFFF.
  - Adds output perf_stall (16 bit), counting RESP cycles with rsp_ready=0, saturating.
  - All counters cleared by rst.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package cpu_pkg:
  - ALU op localparams: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4, ALU_NE=5, ALU_EQ=6.
  - OP_W.
  - arbiter state enum (IDLE, EXEC, RESP).
- Sub-module: rr_arb2, a 2-way round-robin picker. Inputs: valid[1:0], last_grant. Output: one-hot grant. Purely combinational.
- FSM, operand registers and perf counters stay in the top module.

Test Plan:
- Single add: req0 valid, a=5, b=7, op=0, rsp_ready=1.
  -> req_ready[0] at cycle 0; rsp_valid at cycle 2; rsp_result=12, rsp_id=0, rsp_err=0.
- Tie after reset: both valid; req0 op=1 a=10 b=3, req1 op=4 a=-1 b=2.
  -> req0 served first with result=7; req1 served next with result=1 (signed slt), rsp_id=1.
- Compare ops: op=6 a=b=9 -> rsp_zero=1. op=5 a=9 b=9 -> rsp_zero=0. Both with rsp_result=0.
- Illegal op 9 from req1.
  -> rsp_valid 1 cycle after accept; rsp_err=1, rsp_result=0, rsp_id=1.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP.
  -> rsp_valid and fields stable; req_ready=0; with ALU_ARB_PERF_EN, perf_stall=4.
- Reset during EXEC.
  -> no rsp_valid; all outputs at reset values next cycle; next accept goes to requester 0 on a tie.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op-codes, op-code width and the ALU arbiter state type.
package cpu_pkg;

  localparam int OP_W = 4;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_SLT = 4;
  localparam int ALU_NE  = 5;
  localparam int ALU_EQ  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone valid requester wins; on a tie the one
// that did not win last time is granted. Purely combinational, one-hot output.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Define ALU_ARB_PERF_EN to add saturating grant/stall performance counters.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = cpu_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]      perf_grant0,
  output logic [15:0]      perf_grant1,
  output logic [15:0]      perf_stall
`endif
);

  // Op classes: arithmetic/logic returns the result, compare returns the flag.
  localparam logic [1:0] CLS_ILLEGAL = 2'd0;
  localparam logic [1:0] CLS_ARITH   = 2'd1;
  localparam logic [1:0] CLS_CMP     = 2'd2;

  function automatic logic [1:0] op_class(input logic [OP_W-1:0] op);
    logic [1:0] cls;
    case (32'(op))
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: cls = CLS_ARITH;
      ALU_NE, ALU_EQ:                             cls = CLS_CMP;
      default:                                    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       grant;
  logic             accept;
  logic             win;
  logic [WIDTH-1:0] win_a, win_b;
  logic [OP_W-1:0]  win_op;

  rr_arb2 u_rr_arb2 (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign win    = grant[1];
  assign win_a  = win ? req1_a  : req0_a;
  assign win_b  = win ? req1_b  : req0_b;
  assign win_op = win ? req1_op : req0_op;
  assign accept = (state_q == IDLE) && (grant != 2'b00);

`ifdef ALU_ARB_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [15:0] perf_grant0_q, perf_grant0_d;
  logic [15:0] perf_grant1_q, perf_grant1_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_grant0_d = perf_grant0_q;
    perf_grant1_d = perf_grant1_q;
    perf_stall_d  = perf_stall_q;
    if (accept && !win) perf_grant0_d = sat_inc(perf_grant0_q);
    if (accept && win)  perf_grant1_d = sat_inc(perf_grant1_q);
    if (state_q == RESP && !rsp_ready) perf_stall_d = sat_inc(perf_stall_q);
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_stall  = perf_stall_q;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 2'b00;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (accept) begin
          alu_a_d      = win_a;
          alu_b_d      = win_b;
          alu_op_d     = win_op;
          rsp_id_d     = win;
          last_grant_d = win;
          if (op_class(win_op) == CLS_ILLEGAL) begin
            // Illegal ops skip the ALU cycle and answer with an error at once.
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_class(alu_op_q) == CLS_CMP) begin
          rsp_result_d = '0;
          rsp_zero_d   = alu_zero;
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = 1'b0;
        end
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
`ifdef ALU_ARB_PERF_EN
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_err_q     <= rsp_err_d;
`ifdef ALU_ARB_PERF_EN
      perf_grant0_q <= perf_grant0_d;
      perf_grant1_q <= perf_grant1_d;
      perf_stall_q  <= perf_stall_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rop [2];
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_stall;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Stand-in ALU: eq/ne raise zero when the comparison holds.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'd0: alu_result = alu_a + alu_b;
      4'd1: alu_result = alu_a - alu_b;
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'd0;
    endcase
    if (alu_op == 4'd5)      alu_zero = (alu_a != alu_b);
    else if (alu_op == 4'd6) alu_zero = (alu_a == alu_b);
    else                     alu_zero = (alu_result == 32'd0);
  end

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: busy flag, cycles since accept, expected response.
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 2;
  bit          m_last = 1'b1;
  logic [31:0] m_a = '0, m_b = '0;
  logic [3:0]  m_op = '0;
  bit          e_id, e_zero, e_err;
  logic [31:0] e_res;

  logic [1:0]  o_rdy;
  logic        o_v, o_id, o_zero, o_err;
  logic [31:0] o_res, o_a, o_b;
  logic [3:0]  o_op;

  task automatic expect_calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                             output logic [31:0] res, output bit zero, output bit err);
    res = 32'd0; zero = 1'b0; err = 1'b0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: zero = (a != b);
      4'd6: zero = (a == b);
      default: err = 1'b1;
    endcase
  endtask

  // One clock cycle: check at negedge, advance the model, then release the
  // consumed request just after the rising edge.
  task automatic step();
    logic [1:0] exp_rdy;
    bit         exp_v;
    bit         id;
    @(negedge clk);
    exp_rdy = 2'b00;
    if (!m_busy) begin
      if (req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
      else                    exp_rdy = req_valid;
    end
    exp_v = m_busy && (m_cnt >= m_lat);
    o_rdy = req_ready; o_v = rsp_valid; o_id = rsp_id; o_res = rsp_result;
    o_zero = rsp_zero; o_err = rsp_err; o_a = alu_a; o_b = alu_b; o_op = alu_op;
    if (m_on) begin
      check_eq("req_ready", req_ready, exp_rdy);
      check_eq("rsp_valid", rsp_valid, exp_v);
      check_eq("alu_a", alu_a, m_a);
      check_eq("alu_b", alu_b, m_b);
      check_eq("alu_op", alu_op, m_op);
      if (exp_v) begin
        check_eq("rsp_id", rsp_id, e_id);
        check_eq("rsp_result", rsp_result, e_res);
        check_eq("rsp_zero", rsp_zero, e_zero);
        check_eq("rsp_err", rsp_err, e_err);
      end
    end
    if (rst) begin
      m_busy = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0; m_op = '0;
      exp_rdy = 2'b00;
    end else if (!m_busy && exp_rdy != 2'b00) begin
      id = exp_rdy[1];
      m_busy = 1'b1; m_cnt = 1; m_last = id;
      m_a = ra[id]; m_b = rb[id]; m_op = rop[id];
      e_id = id;
      expect_calc(ra[id], rb[id], rop[id], e_res, e_zero, e_err);
      m_lat = e_err ? 1 : 2;
    end else begin
      exp_rdy = 2'b00;
      if (m_busy) begin
        if (exp_v && rsp_ready) m_busy = 1'b0;
        else m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~exp_rdy;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    ra[i] = a; rb[i] = b; rop[i] = op;
    req_valid[i] = 1'b1;
  endtask

  task automatic reset_dut();
    m_on = 1'b0;
    rst = 1'b1;
    req_valid = 2'b00;
    step();
    step();
    rst = 1'b0;
    m_on = 1'b1;
    step();
    check_eq("rst_valid", o_v, 1'b0);
    check_eq("rst_rdy", o_rdy, 2'b00);
    check_eq("rst_id", o_id, 1'b0);
    check_eq("rst_result", o_res, 32'd0);
    check_eq("rst_zero", o_zero, 1'b0);
    check_eq("rst_err", o_err, 1'b0);
    check_eq("rst_alu", {o_a, o_b, o_op}, 68'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end
    #1;
    reset_dut();

    // Single add from requester 0
    rsp_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, 4'd0);
    step(); check_eq("add_rdy", o_rdy, 2'b01);
    step(); check_eq("add_exec_v", o_v, 1'b0);
    step(); check_eq("add_v", o_v, 1'b1);
    check_eq("add_res", o_res, 32'd12);
    check_eq("add_id", o_id, 1'b0);
    check_eq("add_err", o_err, 1'b0);

    // Tie after reset: requester 0 first, then requester 1
    reset_dut();
    rsp_ready = 1'b1;
    set_req(0, 32'd10, 32'd3, 4'd1);
    set_req(1, 32'hFFFF_FFFF, 32'd2, 4'd4);
    step(); check_eq("tie_rdy0", o_rdy, 2'b01);
    step(); check_eq("tie_wait", o_rdy, 2'b00);
    step(); check_eq("tie_res0", o_res, 32'd7); check_eq("tie_id0", o_id, 1'b0);
    step(); check_eq("tie_rdy1", o_rdy, 2'b10);
    step();
    step(); check_eq("tie_res1", o_res, 32'd1); check_eq("tie_id1", o_id, 1'b1);

    // Compare ops
    set_req(0, 32'd9, 32'd9, 4'd6);
    step(); step(); step();
    check_eq("eq_zero", o_zero, 1'b1); check_eq("eq_res", o_res, 32'd0);
    set_req(0, 32'd9, 32'd9, 4'd5);
    step(); step(); step();
    check_eq("ne_zero", o_zero, 1'b0); check_eq("ne_res", o_res, 32'd0);

    // Illegal op from requester 1
    set_req(1, 32'd3, 32'd4, 4'd9);
    step(); check_eq("ill_rdy", o_rdy, 2'b10);
    step(); check_eq("ill_v", o_v, 1'b1);
    check_eq("ill_err", o_err, 1'b1);
    check_eq("ill_res", o_res, 32'd0);
    check_eq("ill_id", o_id, 1'b1);

    // Backpressure for four RESP cycles
    rsp_ready = 1'b0;
    set_req(0, 32'd1, 32'd2, 4'd0);
    step(); step();
    set_req(1, 32'd4, 32'd4, 4'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("bp_v", o_v, 1'b1);
      check_eq("bp_res", o_res, 32'd3);
      check_eq("bp_rdy", o_rdy, 2'b00);
    end
`ifdef ALU_ARB_PERF_EN
    check_eq("perf_stall", perf_stall, 16'd4);
`endif
    rsp_ready = 1'b1;
    step();
    step(); check_eq("bp_next_rdy", o_rdy, 2'b10);
    step(); step();

    // Reset while an op is in EXEC
    set_req(0, 32'd2, 32'd2, 4'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 32'd6, 32'd1, 4'd1);
    set_req(1, 32'd6, 32'd1, 4'd0);
    step();
    check_eq("mid_v", o_v, 1'b0);
    check_eq("mid_res", o_res, 32'd0);
    check_eq("mid_alu_a", o_a, 32'd0);
    check_eq("mid_rdy", o_rdy, 2'b01);
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
